kanagawa_dcfifo_write_arbiter: RTL and testbench

//  Shares the write port of one dual-clock FIFO among NUM_REQ requesters in the write-clock domain.

---
 rtl/kanagawa_dcfifo_write_arbiter_if.sv | 31 +++
 rtl/kanagawa_dcfifo_write_arbiter.sv | 118 +++++++++++
 tb/tb_kanagawa_dcfifo_write_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/kanagawa_dcfifo_write_arbiter_if.sv
// Requester and FIFO write-port bundle for the dual-clock FIFO write arbiter.
// The arbiter takes the slave modport; the requesters/FIFO side takes master.
interface kanagawa_dcfifo_write_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 32,
    parameter int TAG_WIDTH = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_last;
    logic [NUM_REQ*WIDTH-1:0]   req_data;
    logic [NUM_REQ-1:0]         req_ready;
    logic                       fifo_wrreq;
    logic [TAG_WIDTH+WIDTH-1:0] fifo_data;
    logic                       fifo_almost_full;
    logic                       fifo_full;
    logic                       locked;
    logic [TAG_WIDTH-1:0]       locked_id;
    logic                       overflow_err;

    // Handshake: beat i moves on a rising clk edge with req_valid[i] & req_ready[i].
    // Ready may depend on valid, never the reverse; valid/last/data hold until taken.
    modport slave (
        input  req_valid, req_last, req_data, fifo_almost_full, fifo_full,
        output req_ready, fifo_wrreq, fifo_data, locked, locked_id, overflow_err
    );

    modport master (
        output req_valid, req_last, req_data, fifo_almost_full, fifo_full,
        input  req_ready, fifo_wrreq, fifo_data, locked, locked_id, overflow_err
    );
endinterface

// File: rtl/kanagawa_dcfifo_write_arbiter.sv
// Round-robin, packet-locked arbiter sharing one DCFIFO write port among NUM_REQ
// requesters; each accepted beat is registered and written as {source, payload}.
module kanagawa_dcfifo_write_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 32,
    parameter int TAG_WIDTH = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    kanagawa_dcfifo_write_arbiter_if.slave bus,
    output logic                 dbg_state_o,
    output logic [TAG_WIDTH-1:0] dbg_rr_ptr_o
);
    if (TAG_WIDTH != $clog2(NUM_REQ) || NUM_REQ < 2) begin : g_param_check
        $error("kanagawa_dcfifo_write_arbiter: TAG_WIDTH must equal clog2(NUM_REQ), NUM_REQ >= 2");
    end

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_e;

    localparam logic [TAG_WIDTH-1:0] LAST_IDX = TAG_WIDTH'(NUM_REQ - 1);

    state_e                     state_q, state_d;
    logic [TAG_WIDTH-1:0]       rr_ptr_q, rr_ptr_d;
    logic [TAG_WIDTH-1:0]       owner_q, owner_d;
    logic                       wrreq_q, wrreq_d;
    logic [TAG_WIDTH+WIDTH-1:0] data_q, data_d;
    logic                       ovf_q, ovf_d;

    logic [TAG_WIDTH:0]         scan_idx;
    logic [TAG_WIDTH-1:0]       winner;
    logic                       found;
    logic [TAG_WIDTH-1:0]       sel;
    logic                       sel_last;
    logic [WIDTH-1:0]           sel_payload;
    logic                       accept_en;
    logic                       accept;

    // Scan rr_ptr, rr_ptr+1, ... wrapping at NUM_REQ (not at 2**TAG_WIDTH).
    always_comb begin
        winner   = rr_ptr_q;
        found    = 1'b0;
        scan_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, rr_ptr_q} + (TAG_WIDTH+1)'(k);
            if (scan_idx >= (TAG_WIDTH+1)'(NUM_REQ)) begin
                scan_idx = scan_idx - (TAG_WIDTH+1)'(NUM_REQ);
            end
            if (!found && bus.req_valid[scan_idx[TAG_WIDTH-1:0]]) begin
                winner = scan_idx[TAG_WIDTH-1:0];
                found  = 1'b1;
            end
        end
    end

    assign sel       = (state_q == S_LOCKED) ? owner_q : winner;
    assign sel_last  = bus.req_last[sel];
    assign accept_en = ~bus.fifo_almost_full & ~bus.fifo_full;
    // With nothing valid, sel falls back to rr_ptr whose valid is 0, so no accept.
    assign accept    = ~rst & accept_en & bus.req_valid[sel];

    always_comb begin
        sel_payload = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel == TAG_WIDTH'(i)) begin
                sel_payload = bus.req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        wrreq_d  = accept;
        data_d   = data_q;
        ovf_d    = ovf_q | (wrreq_q & bus.fifo_full);
        if (accept) begin
            data_d  = {sel, sel_payload};
            owner_d = sel;
            // In LOCKED the pointer already moved past the owner when the packet began.
            if (state_q == S_IDLE) begin
                rr_ptr_d = (sel == LAST_IDX) ? '0 : sel + 1'b1;
            end
            state_d = sel_last ? S_IDLE : S_LOCKED;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            wrreq_q  <= 1'b0;
            data_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            wrreq_q  <= wrreq_d;
            data_q   <= data_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.req_ready    = accept ? (NUM_REQ'(1) << sel) : '0;
    assign bus.fifo_wrreq   = wrreq_q;
    assign bus.fifo_data    = data_q;
    assign bus.locked       = (state_q == S_LOCKED);
    assign bus.locked_id    = owner_q;
    assign bus.overflow_err = ovf_q;

    assign dbg_state_o  = state_q;
    assign dbg_rr_ptr_o = rr_ptr_q;
endmodule

// File: tb/tb_kanagawa_dcfifo_write_arbiter.sv
// Directed bench for kanagawa_dcfifo_write_arbiter: queue-based requesters, a
// behavioural arbitration model checked every cycle, and literal per-test pins.
module tb_kanagawa_dcfifo_write_arbiter;
    localparam int NR = 4;
    localparam int W  = 32;
    localparam int TW = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    kanagawa_dcfifo_write_arbiter_if #(.NUM_REQ(NR), .WIDTH(W), .TAG_WIDTH(TW)) ifc ();
    logic          dbg_state;
    logic [TW-1:0] dbg_rr;

    kanagawa_dcfifo_write_arbiter #(.NUM_REQ(NR), .WIDTH(W), .TAG_WIDTH(TW)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (ifc),
        .dbg_state_o  (dbg_state),
        .dbg_rr_ptr_o (dbg_rr)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] mkdata(input int t, input int r, input int b);
        return W'(32'hD000_0000 + t * 65536 + r * 256 + b);
    endfunction

    // ---------------- requester queues (driver side) ----------------
    logic [W:0]    bmem [NR][32];
    int            bhead [NR];
    int            btail [NR];
    logic [NR-1:0] acc_lat = '0;

    task automatic push_beat(input int r, input logic [W-1:0] d, input logic last);
        bmem[r][btail[r]] = {last, d};
        btail[r]++;
    endtask

    task automatic push_packet(input int t, input int r, input int nbeats);
        for (int b = 0; b < nbeats; b++) push_beat(r, mkdata(t, r, b), (b == nbeats - 1));
    endtask

    function automatic bit all_empty();
        for (int r = 0; r < NR; r++) if (bhead[r] != btail[r]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drive_reqs();
        for (int r = 0; r < NR; r++) begin
            if (bhead[r] != btail[r]) begin
                ifc.req_valid[r]          = 1'b1;
                ifc.req_last[r]           = bmem[r][bhead[r]][W];
                ifc.req_data[r*W +: W]    = bmem[r][bhead[r]][W-1:0];
            end else begin
                ifc.req_valid[r]          = 1'b0;
                ifc.req_last[r]           = 1'b0;
                ifc.req_data[r*W +: W]    = '0;
            end
        end
    endtask

    always @(posedge clk) begin
        #1;
        for (int r = 0; r < NR; r++) begin
            if (acc_lat[r] && bhead[r] != btail[r]) bhead[r]++;
        end
        acc_lat = '0;
        drive_reqs();
    end

    // ---------------- behavioural model + scoreboard ----------------
    int                  m_owner   = -1;   // -1: no packet in progress
    int                  m_rr      = 0;
    int                  m_last_id = 0;
    bit                  m_ovf     = 1'b0;
    logic [TW+W-1:0]     m_hold    = '0;
    logic [TW+W-1:0]     exp_q[$];

    int                  ncyc = 0;
    int                  log_tag[$];
    logic [W-1:0]        log_pay[$];
    logic                log_lock[$];
    int                  log_cyc[$];

    // Upstream shares the reset: queues and valids drop immediately.
    always @(posedge rst) begin
        for (int r = 0; r < NR; r++) begin
            bhead[r] = 0;
            btail[r] = 0;
        end
        ifc.req_valid = '0;
        ifc.req_last  = '0;
        acc_lat       = '0;
        m_owner       = -1;
        m_rr          = 0;
        m_last_id     = 0;
        m_ovf         = 1'b0;
        m_hold        = '0;
        exp_q.delete();
    end

    always @(negedge clk) begin : cmp
        logic [NR-1:0]   exp_ready;
        logic [TW+W-1:0] exp_data;
        int              cand;
        int              r;
        bit              en;
        bit              exp_wr;
        ncyc++;
        if (rst) begin
            check("rst_req_ready", ifc.req_ready, 0);
            check("rst_fifo_wrreq", ifc.fifo_wrreq, 0);
            check("rst_locked", ifc.locked, 0);
            check("rst_overflow", ifc.overflow_err, 0);
        end else begin
            cand = -1;
            if (m_owner >= 0) begin
                if (ifc.req_valid[m_owner]) cand = m_owner;
            end else begin
                for (int k = 0; k < NR; k++) begin
                    r = (m_rr + k) % NR;
                    if (cand < 0 && ifc.req_valid[r]) cand = r;
                end
            end
            en        = !ifc.fifo_almost_full && !ifc.fifo_full;
            exp_ready = (cand >= 0 && en) ? (NR'(1) << cand) : '0;
            exp_wr    = (exp_q.size() > 0);
            exp_data  = exp_wr ? exp_q[0] : m_hold;

            check("req_ready", ifc.req_ready, exp_ready);
            check("fifo_wrreq", ifc.fifo_wrreq, exp_wr);
            check("fifo_data", ifc.fifo_data, exp_data);
            check("locked", ifc.locked, (m_owner >= 0));
            check("locked_id", ifc.locked_id, m_last_id);
            check("overflow_err", ifc.overflow_err, m_ovf);

            if (exp_wr) m_hold = exp_q.pop_front();
            if (ifc.fifo_wrreq) begin
                log_tag.push_back(int'(ifc.fifo_data[TW+W-1:W]));
                log_pay.push_back(ifc.fifo_data[W-1:0]);
                log_lock.push_back(ifc.locked);
                log_cyc.push_back(ncyc);
            end
            if (exp_wr && ifc.fifo_full) m_ovf = 1'b1;
            if (exp_ready != '0) begin
                exp_q.push_back({TW'(cand), ifc.req_data[cand*W +: W]});
                m_last_id = cand;
                if (m_owner < 0) m_rr = (cand + 1) % NR;
                m_owner = ifc.req_last[cand] ? -1 : cand;
            end
            acc_lat = ifc.req_ready & ifc.req_valid;
        end
    end

    // ---------------- directed sequence ----------------
    int exp_tags[6];
    int exp_lock[6];

    task automatic clear_log();
        log_tag.delete();
        log_pay.delete();
        log_lock.delete();
        log_cyc.delete();
    endtask

    task automatic wait_drain(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (all_empty() && !ifc.fifo_wrreq) done = 1'b1;
        end
        check({name, "_drain"}, done, 1'b1);
    endtask

    task automatic check_tags(input string name, input int n, input bit with_lock);
        check({name, "_count"}, log_tag.size(), n);
        for (int i = 0; i < n && i < log_tag.size(); i++) begin
            check($sformatf("%s_tag%0d", name, i), log_tag[i], exp_tags[i]);
            if (with_lock) check($sformatf("%s_lock%0d", name, i), log_lock[i], exp_lock[i]);
        end
    endtask

    initial begin
        ifc.req_valid        = '0;
        ifc.req_last         = '0;
        ifc.req_data         = '0;
        ifc.fifo_almost_full = 1'b0;
        ifc.fifo_full        = 1'b0;
        for (int r = 0; r < NR; r++) begin
            bhead[r] = 0;
            btail[r] = 0;
        end
        #1;

        // Reset with every requester valid; also preloads the round-robin test.
        push_packet(2, 0, 1);
        push_beat(0, mkdata(2, 0, 1), 1'b1);
        push_packet(2, 1, 1);
        push_beat(1, mkdata(2, 1, 1), 1'b1);
        push_packet(2, 2, 1);
        push_packet(2, 3, 1);
        repeat (2) @(negedge clk);
        check("t1_valid_applied", ifc.req_valid, 4'hF);
        check("t1_req_ready", ifc.req_ready, 0);
        check("t1_fifo_wrreq", ifc.fifo_wrreq, 0);
        check("t1_locked", ifc.locked, 0);
        check("t1_overflow", ifc.overflow_err, 0);
        @(posedge clk);
        #3 rst = 1'b0;

        // Round-robin over single-beat packets, no bubbles.
        wait_drain("t2");
        exp_tags = '{0, 1, 2, 3, 0, 1};
        check_tags("t2", 6, 1'b0);
        for (int i = 1; i < 6 && i < log_cyc.size(); i++) begin
            check($sformatf("t2_gap%0d", i), log_cyc[i] - log_cyc[i-1], 1);
        end
        check("t2_rr_ptr", dbg_rr, 2);

        // Packet lock: req1 holds the port for 3 beats while req0/req2 wait.
        @(negedge clk); #1;
        clear_log();
        push_packet(3, 0, 1);
        wait_drain("t3a");
        @(negedge clk); #1;
        push_packet(3, 1, 3);
        push_packet(3, 0, 1);
        push_packet(3, 2, 1);
        wait_drain("t3");
        exp_tags = '{0, 1, 1, 1, 2, 0};
        exp_lock = '{0, 1, 1, 0, 0, 0};
        check_tags("t3", 6, 1'b1);

        // almost_full stalls beat 2 for 5 cycles; lock held, payload intact.
        @(negedge clk); #1;
        clear_log();
        push_packet(4, 1, 3);
        @(posedge clk);
        @(posedge clk);
        #1 ifc.fifo_almost_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("t4_stall_ready%0d", i), ifc.req_ready, 0);
            check($sformatf("t4_stall_lock%0d", i), {ifc.locked, ifc.locked_id}, {1'b1, 2'd1});
        end
        @(posedge clk);
        #1 ifc.fifo_almost_full = 1'b0;
        wait_drain("t4");
        exp_tags = '{1, 1, 1, 0, 0, 0};
        check_tags("t4", 3, 1'b0);
        for (int i = 0; i < 3 && i < log_pay.size(); i++) begin
            check($sformatf("t4_pay%0d", i), log_pay[i], mkdata(4, 1, i));
        end
        if (log_cyc.size() >= 3) begin
            check("t4_beat2_delay", log_cyc[1] - log_cyc[0], 6);
            check("t4_beat3_delay", log_cyc[2] - log_cyc[1], 1);
        end

        // Write strobe while full sets the sticky overflow flag.
        @(negedge clk); #1;
        push_packet(5, 2, 1);
        @(posedge clk);
        @(posedge clk);
        #1 ifc.fifo_full = 1'b1;
        @(negedge clk);
        check("t5_wrreq", ifc.fifo_wrreq, 1);
        check("t5_ovf_before", ifc.overflow_err, 0);
        @(posedge clk);
        #1 ifc.fifo_full = 1'b0;
        @(negedge clk);
        check("t5_ovf_set", ifc.overflow_err, 1);
        repeat (3) @(negedge clk);
        check("t5_ovf_sticky", ifc.overflow_err, 1);

        // Asynchronous reset in the middle of a locked packet.
        @(negedge clk); #1;
        clear_log();
        push_packet(6, 2, 3);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #2;
        check("t6_locked_before", {ifc.locked, ifc.locked_id}, {1'b1, 2'd2});
        #1 rst = 1'b1;
        #1;
        check("t6_rst_ready", ifc.req_ready, 0);
        check("t6_rst_wrreq", ifc.fifo_wrreq, 0);
        check("t6_rst_locked", ifc.locked, 0);
        check("t6_rst_locked_id", ifc.locked_id, 0);
        check("t6_rst_data", ifc.fifo_data, 0);
        check("t6_rst_overflow", ifc.overflow_err, 0);
        rst = 1'b0;
        @(negedge clk); #1;
        clear_log();
        push_packet(6, 3, 1);
        push_packet(6, 0, 1);
        wait_drain("t6");
        exp_tags = '{0, 3, 0, 0, 0, 0};
        check_tags("t6", 2, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
